// File: rtl/uart_cmd_master.sv
// uart_cmd_master: ASCII hex register command master over an 8N1 UART.
// Optional echo content check: define UART_CMD_ECHO_CHK_EN.
module uart_cmd_master #(
  parameter int C_F_CK      = 135_000_000,
  parameter int C_BAUD      = 31_250,
  parameter int C_TMO_BYTES = 16
) (
  input  logic       CK_i,
  input  logic       ARST_i,
  input  logic       REQ_i,
  input  logic       WR_i,
  input  logic [7:0] ADRs_i,
  input  logic [7:0] WDATs_i,
  output logic       BUSY_o,
  output logic       DONE_o,
  output logic       ERR_o,
  output logic [7:0] RDATs_o,
  output logic       TXD_o,
  input  logic       RXD_i
);
  localparam int C_BIT  = C_F_CK / C_BAUD;
  localparam int C_HALF = C_BIT / 2;
  localparam int C_TMO  = C_TMO_BYTES * 10 * C_BIT;
  localparam int CW     = $clog2(C_BIT + 1);
  localparam int TW     = $clog2(C_TMO + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t          r_state, n_state;
  logic            r_wr;
  logic [7:0]      r_adr, r_dat;
  logic [2:0]      r_tx_idx;
  logic [3:0]      r_tx_bit;
  logic [CW-1:0]   r_tx_cnt;
  logic [TW-1:0]   r_tmo;
  logic            r_rx_s1, r_rx_s2, r_rx_s3;
  logic            r_rx_act;
  logic [CW-1:0]   r_rx_cnt;
  logic [3:0]      r_rx_bit;
  logic [7:0]      r_rx_sh;
  logic [2:0]      r_rx_n;
  logic [3:0]      r_hi;
  logic [7:0]      r_rdat;
  logic            r_done, r_err;
  logic            n_done, n_err;

  logic [7:0]      w_tx_byte;
  logic [2:0]      w_bi;
  logic            w_tx_end, w_last_tx;
  logic            w_rx_fall, w_rx_tick, w_rx_evt, w_rx_ferr;
  logic [4:0]      w_nib;
  logic [2:0]      w_n;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : ({4'h0, n} + 8'h37);
  endfunction

  // {valid, value} for an ASCII hex digit of either case
  function automatic logic [4:0] f_nib(input logic [7:0] c);
    logic [4:0] v;
    v = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      v = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66))
      v = {1'b1, c[3:0] + 4'd9};
    return v;
  endfunction

  function automatic logic [7:0] f_byte(
    input logic [2:0] idx,
    input logic       wr,
    input logic [7:0] adr,
    input logic [7:0] dat
  );
    logic [7:0] b;
    unique case (idx)
      3'd0:    b = wr ? 8'h57 : 8'h52;
      3'd1:    b = f_hex(adr[7:4]);
      3'd2:    b = f_hex(adr[3:0]);
      3'd3:    b = wr ? f_hex(dat[7:4]) : 8'h0D;
      3'd4:    b = f_hex(dat[3:0]);
      default: b = 8'h0D;
    endcase
    return b;
  endfunction

  assign w_tx_byte = f_byte(r_tx_idx, r_wr, r_adr, r_dat);
  assign w_bi      = 3'(r_tx_bit - 4'd1);
  assign w_n       = r_wr ? 3'd6 : 3'd4;
  assign w_last_tx = (r_tx_idx == 3'(w_n - 3'd1));
  assign w_tx_end  = (r_tx_cnt == CW'(C_BIT - 1)) &&
                     (r_tx_bit == 4'd9);

  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
  assign w_rx_tick = r_rx_act && (r_rx_cnt == '0);
  assign w_rx_evt  = w_rx_tick && (r_rx_bit == 4'd9);
  assign w_rx_ferr = w_rx_evt && !r_rx_s2;
  assign w_nib     = f_nib(r_rx_sh);

  always_comb begin
    TXD_o = 1'b1;
    if (r_state == S_SEND) begin
      if (r_tx_bit == 4'd0)
        TXD_o = 1'b0;
      else if (r_tx_bit <= 4'd8)
        TXD_o = w_tx_byte[w_bi];
    end
  end

  always_comb begin
    n_state = r_state;
    n_done  = 1'b0;
    n_err   = 1'b0;
    unique case (r_state)
      S_IDLE: if (REQ_i) n_state = S_SEND;
      S_SEND, S_WAIT: begin
        if (r_state == S_SEND && w_tx_end && w_last_tx)
          n_state = S_WAIT;
        if (r_state == S_WAIT && !w_rx_evt &&
            r_tmo == TW'(C_TMO - 1))
          n_err = 1'b1;
        if (w_rx_evt) begin
          if (w_rx_ferr) begin
            n_err = 1'b1;
          end else if (r_rx_n < w_n) begin
`ifdef UART_CMD_ECHO_CHK_EN
            if (r_rx_sh != f_byte(r_rx_n, r_wr, r_adr, r_dat))
              n_err = 1'b1;
`endif
            if (r_wr && r_rx_n == 3'd5) n_done = 1'b1;
          end else if (!w_nib[4]) begin
            n_err = 1'b1;
          end else if (r_rx_n == 3'd5) begin
            n_done = 1'b1;
          end
        end
        if (n_err) n_done = 1'b0;
        if (n_err || n_done) n_state = S_IDLE;
      end
      default: n_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdat  <= 8'h00;
    end else begin
      r_state <= n_state;
      r_done  <= n_done;
      r_err   <= n_err;
      if (n_done && !r_wr) r_rdat <= {r_hi, w_nib[3:0]};
    end
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      r_wr     <= 1'b0;
      r_adr    <= 8'h00;
      r_dat    <= 8'h00;
      r_tx_idx <= 3'd0;
      r_tx_bit <= 4'd0;
      r_tx_cnt <= '0;
      r_tmo    <= '0;
      r_rx_n   <= 3'd0;
      r_hi     <= 4'd0;
    end else begin
      if (r_state == S_IDLE && REQ_i) begin
        r_wr     <= WR_i;
        r_adr    <= ADRs_i;
        r_dat    <= WDATs_i;
        r_tx_idx <= 3'd0;
        r_tx_bit <= 4'd0;
        r_tx_cnt <= '0;
        r_rx_n   <= 3'd0;
      end else if (r_state == S_SEND) begin
        if (r_tx_cnt == CW'(C_BIT - 1)) begin
          r_tx_cnt <= '0;
          if (r_tx_bit == 4'd9) begin
            r_tx_bit <= 4'd0;
            r_tx_idx <= r_tx_idx + 3'd1;
          end else begin
            r_tx_bit <= r_tx_bit + 4'd1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
        end
      end
      if (r_state != S_IDLE && w_rx_evt && !w_rx_ferr) begin
        r_rx_n <= r_rx_n + 3'd1;
        if (!r_wr && r_rx_n == 3'd4) r_hi <= w_nib[3:0];
      end
      if (r_state == S_WAIT)
        r_tmo <= w_rx_evt ? '0 : r_tmo + 1'b1;
      else
        r_tmo <= '0;
    end
  end

  // Receiver: 2-flop sync plus one history flop for edge detect
  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_s3  <= 1'b1;
      r_rx_act <= 1'b0;
      r_rx_cnt <= '0;
      r_rx_bit <= 4'd0;
      r_rx_sh  <= 8'h00;
    end else begin
      r_rx_s1 <= RXD_i;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      if (!r_rx_act) begin
        if (w_rx_fall) begin
          r_rx_act <= 1'b1;
          r_rx_cnt <= CW'(C_HALF - 1);
          r_rx_bit <= 4'd0;
        end
      end else if (r_rx_cnt != '0) begin
        r_rx_cnt <= r_rx_cnt - 1'b1;
      end else begin
        r_rx_cnt <= CW'(C_BIT - 1);
        r_rx_bit <= r_rx_bit + 4'd1;
        if (r_rx_bit == 4'd0 && r_rx_s2)
          r_rx_act <= 1'b0;
        else if (r_rx_bit == 4'd9)
          r_rx_act <= 1'b0;
        else if (r_rx_bit != 4'd0)
          r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
      end
    end
  end

  assign BUSY_o  = (r_state != S_IDLE);
  assign DONE_o  = r_done;
  assign ERR_o   = r_err;
  assign RDATs_o = r_rdat;

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: vector table plus corner sequences,
// TX bytes checked against a scoreboard queue.
module tb_uart_cmd_master;
  localparam int C_BIT = 10;
`ifdef UART_CMD_ECHO_CHK_EN
  localparam logic ECHO = 1'b1;
`else
  localparam logic ECHO = 1'b0;
`endif

  logic       CK_i = 1'b0;
  logic       ARST_i = 1'b1;
  logic       REQ_i = 1'b0;
  logic       WR_i = 1'b0;
  logic [7:0] ADRs_i = 8'h00;
  logic [7:0] WDATs_i = 8'h00;
  logic       BUSY_o, DONE_o, ERR_o, TXD_o;
  logic [7:0] RDATs_o;
  logic       RXD_i;
  logic       r_loop = 1'b0;
  logic       r_rxd = 1'b1;

  assign RXD_i = r_loop ? TXD_o : r_rxd;

  uart_cmd_master #(
    .C_F_CK(1000), .C_BAUD(100), .C_TMO_BYTES(16)
  ) dut (
    .CK_i(CK_i), .ARST_i(ARST_i), .REQ_i(REQ_i),
    .WR_i(WR_i), .ADRs_i(ADRs_i), .WDATs_i(WDATs_i),
    .BUSY_o(BUSY_o), .DONE_o(DONE_o), .ERR_o(ERR_o),
    .RDATs_o(RDATs_o), .TXD_o(TXD_o), .RXD_i(RXD_i)
  );

  always #5 CK_i = ~CK_i;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int c_done = 0;
  int c_err = 0;
  logic [7:0] sb[$];

  typedef struct packed {
    logic        wr;
    logic [7:0]  adr;
    logic [7:0]  dat;
    logic        loop;
    logic        glitch;
    logic [2:0]  nrsp;
    logic [47:0] rsp;
    logic [2:0]  bad;
    logic        exp_done;
    logic [7:0]  exp_rdat;
  } vec_t;

  vec_t tv[9];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge CK_i) cyc++;

  always @(negedge CK_i) begin
    if (DONE_o) c_done++;
    if (ERR_o) c_err++;
    if (DONE_o || ERR_o) begin
      check("busy drop on pulse", BUSY_o, 0);
      check("done and err together", DONE_o & ERR_o, 0);
    end
  end

  bit         m_act = 0;
  int         m_cnt = 0;
  logic [7:0] m_sh = 8'h00;
  always @(negedge CK_i) begin
    if (ARST_i || !BUSY_o) begin
      m_act = 0;
    end else if (!m_act) begin
      if (TXD_o == 1'b0) begin
        m_act = 1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt % 10 == 5 && m_cnt > 5 && m_cnt < 95)
        m_sh = {TXD_o, m_sh[7:1]};
      if (m_cnt == 95) begin
        m_act = 0;
        check("tx stop bit", TXD_o, 1);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx unexpected byte: got %0h expected none", m_sh);
        end else begin
          check("tx byte", m_sh, sb.pop_front());
        end
      end
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
  endfunction

  function automatic vec_t mk(
    input logic wr, input logic [7:0] adr, input logic [7:0] dat,
    input logic loop, input logic glitch, input logic [2:0] nrsp,
    input logic [47:0] rsp, input logic [2:0] bad,
    input logic exp_done, input logic [7:0] exp_rdat);
    vec_t v;
    v.wr = wr; v.adr = adr; v.dat = dat; v.loop = loop;
    v.glitch = glitch; v.nrsp = nrsp; v.rsp = rsp; v.bad = bad;
    v.exp_done = exp_done; v.exp_rdat = exp_rdat;
    return v;
  endfunction

  task automatic push_cmd(input logic wr, input logic [7:0] adr,
                          input logic [7:0] dat);
    sb.push_back(wr ? 8'h57 : 8'h52);
    sb.push_back(hexc(adr[7:4]));
    sb.push_back(hexc(adr[3:0]));
    if (wr) begin
      sb.push_back(hexc(dat[7:4]));
      sb.push_back(hexc(dat[3:0]));
    end
    sb.push_back(8'h0D);
  endtask

  task automatic issue(input logic wr, input logic [7:0] adr,
                       input logic [7:0] dat);
    @(negedge CK_i);
    REQ_i = 1; WR_i = wr; ADRs_i = adr; WDATs_i = dat;
    @(negedge CK_i);
    REQ_i = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    r_rxd = 0;
    repeat (C_BIT) @(negedge CK_i);
    for (int i = 0; i < 8; i++) begin
      r_rxd = b[i];
      repeat (C_BIT) @(negedge CK_i);
    end
    r_rxd = stop;
    repeat (C_BIT) @(negedge CK_i);
    r_rxd = 1;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (BUSY_o && t < 4000) begin
      @(negedge CK_i);
      t++;
    end
    check({nm, " busy timeout"}, BUSY_o, 0);
    repeat (20) @(negedge CK_i);
  endtask

  task automatic run_txn(input vec_t v, input int k);
    int d0 = c_done;
    int e0 = c_err;
    string nm = $sformatf("vec%0d", k);
    push_cmd(v.wr, v.adr, v.dat);
    r_loop = v.loop;
    issue(v.wr, v.adr, v.dat);
    if (v.glitch) begin
      r_rxd = 0;
      repeat (3) @(negedge CK_i);
      r_rxd = 1;
      repeat (20) @(negedge CK_i);
    end
    for (int i = 0; i < int'(v.nrsp); i++)
      send_byte(v.rsp[47-8*i -: 8], i != int'(v.bad));
    wait_idle(nm);
    check({nm, " done count"}, c_done - d0, {31'd0, v.exp_done});
    check({nm, " err count"}, c_err - e0, {31'd0, !v.exp_done});
    check({nm, " rdata"}, RDATs_o, v.exp_rdat);
    if (v.exp_done) check({nm, " tx bytes left"}, sb.size(), 0);
    sb.delete();
    r_loop = 0;
  endtask

  initial begin
    int d0, e0, t, t0;
    tv[0] = mk(1, 8'h12, 8'hAB, 1, 0, 0, 48'h0, 7, 1, 8'h00);
    tv[1] = mk(0, 8'h3C, 8'h00, 0, 0, 6, 48'h5233430D3566, 7, 1, 8'h5F);
    tv[2] = mk(1, 8'hFF, 8'h09, 1, 0, 0, 48'h0, 7, 1, 8'h5F);
    tv[3] = mk(0, 8'hA5, 8'h00, 0, 0, 6, 48'h5241350D6130, 7, 1, 8'hA0);
    tv[4] = mk(0, 8'h3C, 8'h00, 0, 0, 6, 48'h5233430D4730, 7, 0, 8'hA0);
    tv[5] = mk(0, 8'h3C, 8'h00, 0, 0, 5, 48'h5233430D3500, 4, 0, 8'hA0);
    tv[6] = mk(0, 8'h3C, 8'h00, 0, 0, 6, 48'h5233440D3566, 7,
               !ECHO, ECHO ? 8'hA0 : 8'h5F);
    tv[7] = mk(0, 8'h3C, 8'h00, 0, 1, 6, 48'h5233430D3132, 7, 1, 8'h12);
    tv[8] = mk(0, 8'hB7, 8'h00, 0, 0, 6, 48'h5242370D3962, 7, 1, 8'h9B);

    ARST_i = 1;
    repeat (3) @(negedge CK_i);
    check("reset busy", BUSY_o, 0);
    check("reset txd", TXD_o, 1);
    check("reset done", DONE_o, 0);
    check("reset err", ERR_o, 0);
    check("reset rdata", RDATs_o, 8'h00);
    ARST_i = 0;

    for (int k = 0; k < 9; k++) run_txn(tv[k], k);

    // silent slave: error exactly one timeout after the last stop bit
    e0 = c_err;
    push_cmd(0, 8'h07, 8'h00);
    issue(0, 8'h07, 8'h00);
    t0 = cyc;
    t = 0;
    while (!ERR_o && t < 3000) begin
      @(negedge CK_i);
      t++;
    end
    check("timeout latency", cyc - t0, 4 * 10 * C_BIT + 1600);
    check("timeout busy", BUSY_o, 0);
    wait_idle("timeout");
    check("timeout err count", c_err - e0, 1);
    check("timeout rdata", RDATs_o, 8'h9B);
    sb.delete();

    // second request while sending must be ignored
    d0 = c_done;
    push_cmd(1, 8'hC4, 8'h3D);
    r_loop = 1;
    issue(1, 8'hC4, 8'h3D);
    repeat (30) @(negedge CK_i);
    REQ_i = 1; WR_i = 0; ADRs_i = 8'hFF;
    @(negedge CK_i);
    REQ_i = 0;
    wait_idle("req ignore");
    check("req ignore done", c_done - d0, 1);
    check("req ignore tx left", sb.size(), 0);
    sb.delete();

    // reset mid-byte, then a request in the first cycle after release
    push_cmd(1, 8'h56, 8'h78);
    issue(1, 8'h56, 8'h78);
    repeat (25) @(negedge CK_i);
    #2 ARST_i = 1;
    #1;
    check("mid reset txd", TXD_o, 1);
    check("mid reset busy", BUSY_o, 0);
    check("mid reset done", DONE_o, 0);
    check("mid reset err", ERR_o, 0);
    check("mid reset rdata", RDATs_o, 8'h00);
    sb.delete();
    repeat (2) @(negedge CK_i);
    d0 = c_done;
    e0 = c_err;
    push_cmd(1, 8'h9E, 8'h0F);
    ARST_i = 0;
    REQ_i = 1; WR_i = 1; ADRs_i = 8'h9E; WDATs_i = 8'h0F;
    @(negedge CK_i);
    REQ_i = 0;
    check("req after reset busy", BUSY_o, 1);
    wait_idle("post reset");
    check("post reset done", c_done - d0, 1);
    check("post reset err", c_err - e0, 0);
    check("post reset tx left", sb.size(), 0);
    r_loop = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_cmd_master.md
UART_CMD_MASTER -- requirements
Module: uart_cmd_master

Interface
REQ-001 SHALL have parameter C_F_CK, default 135_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter C_BAUD, default 31_250, meaning line rate in bps; bit period C_BIT = C_F_CK/C_BAUD clocks, integer division.
REQ-003 SHALL have parameter C_TMO_BYTES, default 16, meaning response timeout in byte times (one byte time = 10*C_BIT).
REQ-004 SHALL have one clock; reset is asynchronous and active-high: CK_i  in  1  clock (all logic on rising edge).
REQ-005 ARST_i  in  1  asynchronous reset, active-high.
REQ-006 REQ_i  in  1  transaction request, sampled only when BUSY_o=0.
REQ-007 WR_i  in  1  1=register write, 0=register read.
REQ-008 ADRs_i  in  8  register address.
REQ-009 WDATs_i  in  8  write data.
REQ-010 BUSY_o  out  1  transaction in progress.
REQ-011 DONE_o  out  1  one-cycle pulse, transaction completed successfully.
REQ-012 ERR_o  out  1  one-cycle pulse, transaction aborted (timeout, framing, bad hex, echo mismatch).
REQ-013 RDATs_o  out  8  read data, valid from the DONE_o pulse of a read until the next read's DONE_o.
REQ-014 TXD_o  out  1  UART transmit line to the slave command parser, idle high.
REQ-015 RXD_i  in  1  UART receive line from the slave, asynchronous.

Function
REQ-016 SHALL, when REQ_i=1 and BUSY_o=0, capture WR_i/ADRs_i/WDATs_i and assert BUSY_o on the next cycle; REQ_i while BUSY_o=1 is ignored.
REQ-017 SHALL transmit a write as 6 ASCII bytes: 'W'(0x57), ADR hi nibble, ADR lo nibble, DAT hi nibble, DAT lo nibble, CR(0x0D).
REQ-018 SHALL transmit a read as 4 ASCII bytes: 'R'(0x52), ADR hi nibble, ADR lo nibble, CR.
REQ-019 SHALL encode each nibble as uppercase hex: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-020 SHALL frame each byte 8N1, LSB first: start bit low, 8 data bits, stop bit high, each C_BIT clocks; bytes are sent back-to-back with no extra idle.
REQ-021 SHALL use states IDLE -> SEND (byte index 0..N-1) -> WAIT_RSP -> IDLE; the first start bit begins within 2 cycles of capture.
REQ-022 SHALL synchronise RXD_i through 2 flops (reset value 1), detect the start-bit falling edge, and sample each bit at mid-period (C_BIT/2 after the edge, then every C_BIT).
REQ-023 SHALL discard a start bit that reads high at mid-period (glitch) and not count it as a byte.
REQ-024 SHALL treat a stop bit sampled low as a framing error: ERR_o pulse, return to IDLE.
REQ-025 SHALL count received bytes from the start of SEND; the first N bytes (6 write, 4 read) are the slave's echo.
REQ-026 SHALL, for a write, pulse DONE_o and return to IDLE one cycle after the 6th echo byte's stop-bit sample.
REQ-027 SHALL, for a read, decode received bytes 5 and 6 as hi/lo hex nibbles (0-9, A-F, a-f accepted), load RDATs_o and pulse DONE_o one cycle after byte 6's stop-bit sample.
REQ-028 SHALL pulse ERR_o on a read response byte outside 0-9/A-F/a-f, and leave RDATs_o unchanged.
REQ-029 SHALL start a timeout counter at the end of the last transmitted stop bit and reload it on every received byte; at C_TMO_BYTES*10*C_BIT clocks it SHALL pulse ERR_o and return to IDLE.
REQ-030 SHALL deassert BUSY_o in the same cycle as the DONE_o or ERR_o pulse; DONE_o and ERR_o SHALL never both be 1.
REQ-031 SHALL discard bytes received while in IDLE.

Reset
REQ-032 SHALL, on ARST_i=1 (including mid-frame), immediately force IDLE, TXD_o=1, BUSY_o=0, DONE_o=0, ERR_o=0, RDATs_o=0x00, and clear all counters.
REQ-033 SHALL, after reset release, accept REQ_i in the first cycle.

Configuration
REQ-034 SHALL, with macro UART_CMD_ECHO_CHK_EN defined, compare every echo byte with the byte sent at the same index, and on the first mismatch pulse ERR_o and return to IDLE.
REQ-035 SHALL, without UART_CMD_ECHO_CHK_EN, count echo bytes without checking content and omit the comparison logic.

Verification (C_F_CK=1000, C_BAUD=100, C_BIT=10)
REQ-036 Write ADR=0x12, DAT=0xAB with a looped-back echoing responder -> TXD bytes 57 31 32 41 42 0D; single DONE_o, ERR_o=0.
REQ-037 Read ADR=0x3C; responder returns 52 33 43 0D 35 66 -> RDATs_o=0x5F, single DONE_o.
REQ-038 Read with silent RXD_i -> ERR_o exactly 1600 clocks after the last stop bit ends; BUSY_o=0.
REQ-039 Read with reply bytes 47 30 ('G') -> ERR_o, RDATs_o unchanged; also stop bit forced low -> ERR_o.
REQ-040 Echo 52 33 44 0D for ADR=0x3C -> ERR_o with UART_CMD_ECHO_CHK_EN defined, DONE_o without it.
REQ-041 REQ_i pulsed during SEND is ignored; ARST_i asserted mid-byte -> TXD_o=1, BUSY_o=0 the same cycle; a new request then completes normally.
